i2s_dac_serializer: RTL
=======================

Name: i2s_dac_serializer

Overview:
- Slave-side audio path stage directly upstream of the WM8731 DAC pins (DACDAT, DACLRCK, BCLK).
- Accepts stereo PCM sample pairs over a valid/ready handshake and buffers one pair.
- Generates BCLK and LRCK from the system clock and shifts samples out MSB-first in Philips I2S format, matching codec register 0x0E = 0x02 (I2S mode, 16-bit, codec in slave mode).
- Replaces the fixed-pattern transmitter in the codec control block.

Parameters:
- DATA_WIDTH, 16: sample width per channel.
- SLOT_WIDTH, 16: BCLK periods per channel slot. Must be >= DATA_WIDTH. Slot bits beyond DATA_WIDTH are sent as 0.
- BCLK_HALF, 16: i_CLK cycles per BCLK half-period. Must be >= 2. At 50 MHz this gives BCLK = 1.5625 MHz and LRCK = 48.828 kHz.

Ports:
- i_CLK  in  1  system clock.
- i_RESET  in  1  asynchronous, active-high reset.
- i_ENABLE  in  1  run enable.
- i_SampleL  in  DATA_WIDTH  left sample, two's complement.
- i_SampleR  in  DATA_WIDTH  right sample.
- i_Valid  in  1  sample pair valid.
- o_Ready  out  1  holding buffer empty; a pair is accepted when i_Valid & o_Ready.
- o_BCLK  out  1  bit clock to codec.
- o_LRCK  out  1  DACLRCK: 0 = left slot, 1 = right slot.
- o_DACDAT  out  1  serial data.
- o_FrameStart  out  1  one-cycle pulse at each frame start.
- o_Underrun  out  1  one-cycle pulse when a frame starts with an empty buffer.
- o_UnderrunCount  out  8  saturating underrun counter.

Behaviour:
- One clock (i_CLK). Reset is asynchronous, active-high (i_RESET).
- Reset values:
  - o_BCLK, o_LRCK, o_DACDAT, o_FrameStart, o_Underrun, o_UnderrunCount = 0.
  - Divider = 0; bit counter k = 2*SLOT_WIDTH-1.
  - Holding buffer empty, so o_Ready = 1 after reset.
  - Shift register = 0.
- Divider:
  - Runs only while i_ENABLE = 1; counts 0..BCLK_HALF-1.
  - On terminal count it wraps and o_BCLK toggles.
  - BCLK period is 2*BCLK_HALF cycles.
  - "Fall event" = the cycle in which o_BCLK is driven 1->0. All serial outputs update only on fall events; the codec samples on the BCLK rising edge.
- Bit counter k:
  - Runs 0..2*SLOT_WIDTH-1.
  - Advances on each fall event and wraps from 2*SLOT_WIDTH-1 to 0.
  - Registered outputs at the fall event that sets k: o_LRCK = (k >= SLOT_WIDTH); o_DACDAT = frame bit (k-1).
- Frame layout and I2S delay:
  - Frame bit 0 = L MSB. Frame bit SLOT_WIDTH = R MSB. Bits in positions >= DATA_WIDTH within a slot are 0.
  - Each bit goes out one BCLK after the LRCK edge. At k=0, the output is bit 2*SLOT_WIDTH-1 of the previous frame (R LSB when SLOT_WIDTH = DATA_WIDTH).
  - Implementation: a 2*SLOT_WIDTH shift register; o_DACDAT takes its MSB, then the register shifts left.
- Frame boundary (fall event with k wrapping to 0):
  - o_FrameStart pulses for one cycle.
  - If the buffer is full: the shift register loads it and the buffer empties; o_Ready returns to 1 in the next cycle.
  - If the buffer is empty: the shift register loads all zeros (muted frame), o_Underrun pulses, and o_UnderrunCount increments, saturating at 255.
- Handshake:
  - The one-entry buffer is written when i_Valid & o_Ready, in any cycle and independent of i_ENABLE.
  - o_Ready = ~full (combinational from the full flag).
  - No bypass: a write in the same cycle as an empty-buffer frame boundary still produces an underrun frame. The written pair plays in the following frame.
- First frame after enable/reset: the first fall event (2*BCLK_HALF cycles after enable) is a frame boundary.
- i_ENABLE = 0 (sampled each cycle):
  - Synchronously returns to the reset state for the divider, k, shift register, o_BCLK, o_LRCK, o_DACDAT and pulses.
  - The holding buffer and o_UnderrunCount are retained.
  - Dropping enable mid-frame truncates that frame; no partial resume.
- Asserting i_RESET mid-frame clears everything, including buffered data, immediately.

Test Plan:
- Reset and power-up (BCLK_HALF=2): assert i_RESET for 3 cycles -> all outputs 0, o_Ready = 1; with i_ENABLE low, o_BCLK stays 0 indefinitely.
- Basic frame (BCLK_HALF=2): load L=16'hA5F0, R=16'h0F5A, then enable -> o_LRCK=0 for 16 BCLK then 1 for 16 BCLK. o_DACDAT sampled on BCLK rises reads 0, A5F0 MSB-first over 16 bits, then 0F5A MSB-first, with each MSB one BCLK after its LRCK edge. o_FrameStart pulses every 128 i_CLK.
- Underrun: enable with no samples -> o_DACDAT constant 0, o_Underrun pulses each frame. After 300 frames o_UnderrunCount = 255.
- Back-pressure: hold i_Valid high with pairs (1,2), (3,4), (5,6) -> o_Ready low until each frame boundary. The frames carry the pairs in order with no loss or duplication and no underrun.
- Enable drop mid-frame: drop i_ENABLE at k=7 with the buffer full -> o_BCLK, o_LRCK, o_DACDAT go to 0 next cycle and the buffer is retained. On re-enable, the buffered pair plays in the first frame.
- Async reset mid-frame: pulse i_RESET between clock edges -> outputs 0 immediately and the buffer empties. After release plus enable, the first frame is an underrun.

Source files
------------

// File: rtl/i2s_dac_serializer_if.sv
// Sample-pair handshake between an upstream audio source and the I2S DAC serializer.
interface i2s_dac_serializer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] i_SampleL;
  logic [DATA_WIDTH-1:0] i_SampleR;
  logic                  i_Valid;
  logic                  o_Ready;

  modport master (
    output i_SampleL,
    output i_SampleR,
    output i_Valid,
    input  o_Ready
  );

  modport slave (
    input  i_SampleL,
    input  i_SampleR,
    input  i_Valid,
    output o_Ready
  );
endinterface

// File: rtl/i2s_dac_serializer.sv
// Philips I2S transmitter for the WM8731 DAC in slave mode: derives BCLK/LRCK from
// i_CLK and shifts a one-deep buffered stereo pair out MSB-first, muting on underrun.
module i2s_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int BCLK_HALF  = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic                  i_ENABLE,
  i2s_dac_serializer_if.slave   s_in,
  output logic                  o_BCLK,
  output logic                  o_LRCK,
  output logic                  o_DACDAT,
  output logic                  o_FrameStart,
  output logic                  o_Underrun,
  output logic [7:0]            o_UnderrunCount
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int K_W        = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);
  localparam logic [K_W-1:0]   K_SLOT   = K_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [K_W-1:0]        bit_k;
  logic [K_W-1:0]        k_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [DATA_WIDTH-1:0] buf_l;
  logic [DATA_WIDTH-1:0] buf_r;
  logic                  full;
  logic                  accept;
  logic                  fall_evt;
  logic                  frame_evt;

  assign s_in.o_Ready = ~full;
  assign accept       = s_in.i_Valid & ~full;
  assign fall_evt     = i_ENABLE & o_BCLK & (div_cnt == DIV_LAST);
  assign frame_evt    = fall_evt & (bit_k == K_LAST);
  assign k_next       = (bit_k == K_LAST) ? '0 : bit_k + 1'b1;

  // Each slot is MSB-aligned; trailing slot bits stay zero.
  always_comb begin
    frame_word = '0;
    frame_word[FRAME_BITS-1 -: DATA_WIDTH] = buf_l;
    frame_word[SLOT_WIDTH-1 -: DATA_WIDTH] = buf_r;
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      div_cnt      <= '0;
      bit_k        <= K_LAST;
      shreg        <= '0;
      o_BCLK       <= 1'b0;
      o_LRCK       <= 1'b0;
      o_DACDAT     <= 1'b0;
      o_FrameStart <= 1'b0;
      o_Underrun   <= 1'b0;
    end else if (!i_ENABLE) begin
      div_cnt      <= '0;
      bit_k        <= K_LAST;
      shreg        <= '0;
      o_BCLK       <= 1'b0;
      o_LRCK       <= 1'b0;
      o_DACDAT     <= 1'b0;
      o_FrameStart <= 1'b0;
      o_Underrun   <= 1'b0;
    end else begin
      o_FrameStart <= 1'b0;
      o_Underrun   <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        o_BCLK  <= ~o_BCLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // The MSB leaving at the frame boundary is the previous frame's last bit,
      // which gives the one-BCLK I2S delay after each LRCK edge.
      if (fall_evt) begin
        bit_k    <= k_next;
        o_LRCK   <= (k_next >= K_SLOT);
        o_DACDAT <= shreg[FRAME_BITS-1];
        if (frame_evt) begin
          o_FrameStart <= 1'b1;
          if (full) begin
            shreg <= frame_word;
          end else begin
            shreg      <= '0;
            o_Underrun <= 1'b1;
          end
        end else begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // Buffer and underrun count survive enable drops; only reset clears them.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      full  <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
    end else if (frame_evt && full) begin
      full <= 1'b0;
    end else if (accept) begin
      full  <= 1'b1;
      buf_l <= s_in.i_SampleL;
      buf_r <= s_in.i_SampleR;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      o_UnderrunCount <= 8'd0;
    end else if (frame_evt && !full && (o_UnderrunCount != 8'hFF)) begin
      o_UnderrunCount <= o_UnderrunCount + 8'd1;
    end
  end

endmodule
